// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer
//   Takes the hps_io ioctl download stream and turns it into region-relative
//   write strobes for the Pisces core's program ROM, graphics ROM and colour
//   PROM. It counts and checksums the accepted bytes, and it owns the core
//   reset. The core is held in reset until a complete image has loaded, and
//   is released after a fixed settle period.
//
// Ports
//   clk_sys      in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   dn_download  in   ioctl download-active level
//   dn_wr        in   ioctl byte strobe (1 cycle)
//   dn_addr[16]  in   ioctl byte address
//   dn_data[8]   in   ioctl byte
//   user_reset   in   OSD / button reset request
//   cpu_we       out  program ROM write strobe
//   gfx_we       out  graphics ROM write strobe
//   prom_we      out  colour PROM write strobe
//   wr_addr[16]  out  region-relative write address
//   wr_data[8]   out  write data
//   core_reset   out  core reset (I_RESET)
//   busy         out  load or settle in progress
//   rom_ok       out  a complete image is present
//   addr_err     out  sticky out-of-range write flag for the current load
//   checksum[8]  out  mod-256 sum of the accepted bytes
//   byte_count[17] out number of accepted bytes, saturating
module rom_load_sequencer #(
  parameter logic [15:0] CPU_END  = 16'h3FFF,
  parameter logic [15:0] GFX_END  = 16'h4FFF,
  parameter logic [15:0] PROM_END = 16'h501F,
  parameter logic [7:0]  HOLD_LEN = 8'd255
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        dn_download,
  input  logic        dn_wr,
  input  logic [15:0] dn_addr,
  input  logic [7:0]  dn_data,
  input  logic        user_reset,
  output logic        cpu_we,
  output logic        gfx_we,
  output logic        prom_we,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        core_reset,
  output logic        busy,
  output logic        rom_ok,
  output logic        addr_err,
  output logic [7:0]  checksum,
  output logic [16:0] byte_count
);

  localparam logic [15:0] GFX_BASE  = CPU_END + 16'd1;
  localparam logic [15:0] PROM_BASE = GFX_END + 16'd1;
  localparam logic [16:0] IMAGE_LEN = {1'b0, PROM_END} + 17'd1;

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

  state_t      state;
  logic        dl_prev;
  logic [7:0]  hold_cnt;

  logic        dl_rise;
  logic        accept;
  logic        sel_cpu;
  logic        sel_gfx;
  logic        sel_prom;
  logic        in_range;
  logic [15:0] rel_addr;
  logic [16:0] count_base;
  logic [7:0]  sum_base;

  always_comb begin
    dl_rise  = dn_download & ~dl_prev;
    // The cycle that enters LOAD can already carry the first byte.
    accept   = dn_wr & dn_download & ((state == LOAD) | dl_rise);
    sel_cpu  = (dn_addr <= CPU_END);
    sel_gfx  = ~sel_cpu & (dn_addr <= GFX_END);
    sel_prom = ~sel_cpu & ~sel_gfx & (dn_addr <= PROM_END);
    in_range = sel_cpu | sel_gfx | sel_prom;
    rel_addr = dn_addr;
    if (sel_gfx)  rel_addr = dn_addr - GFX_BASE;
    if (sel_prom) rel_addr = dn_addr - PROM_BASE;
    // A new download discards the previous image's totals, including for a
    // byte accepted on the entry cycle itself.
    count_base = dl_rise ? 17'd0 : byte_count;
    sum_base   = dl_rise ? 8'd0  : checksum;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      // Treated as already high so a download level held through reset does
      // not look like a fresh rising edge.
      dl_prev    <= 1'b1;
      hold_cnt   <= 8'd0;
      cpu_we     <= 1'b0;
      gfx_we     <= 1'b0;
      prom_we    <= 1'b0;
      wr_addr    <= 16'd0;
      wr_data    <= 8'd0;
      core_reset <= 1'b1;
      busy       <= 1'b0;
      rom_ok     <= 1'b0;
      addr_err   <= 1'b0;
      checksum   <= 8'd0;
      byte_count <= 17'd0;
    end else begin
      dl_prev <= dn_download;
      cpu_we  <= 1'b0;
      gfx_we  <= 1'b0;
      prom_we <= 1'b0;

      if (dl_rise) begin
        checksum   <= 8'd0;
        byte_count <= 17'd0;
        addr_err   <= 1'b0;
        rom_ok     <= 1'b0;
      end

      // Write path
      if (accept) begin
        if (in_range) begin
          cpu_we     <= sel_cpu;
          gfx_we     <= sel_gfx;
          prom_we    <= sel_prom;
          wr_addr    <= rel_addr;
          wr_data    <= dn_data;
          checksum   <= sum_base + dn_data;
          byte_count <= (&count_base) ? count_base : count_base + 17'd1;
        end else begin
          addr_err <= 1'b1;
        end
      end

      // Sequencer; a download edge outranks everything, including user_reset
      if (dl_rise) begin
        state      <= LOAD;
        busy       <= 1'b1;
        core_reset <= 1'b1;
      end else begin
        case (state)
          LOAD: begin
            if (!dn_download) begin
              state    <= HOLD;
              hold_cnt <= 8'd0;
            end
          end
          HOLD: begin
            if (hold_cnt == HOLD_LEN) begin
              busy <= 1'b0;
              if ((byte_count >= IMAGE_LEN) && !addr_err) begin
                state      <= RUN;
                rom_ok     <= 1'b1;
                core_reset <= 1'b0;
              end else begin
                state  <= IDLE;
                rom_ok <= 1'b0;
              end
            end else begin
              hold_cnt <= hold_cnt + 8'd1;
            end
          end
          RUN: begin
            if (user_reset) begin
              state      <= HOLD;
              hold_cnt   <= 8'd0;
              core_reset <= 1'b1;
              busy       <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_load_sequencer.sv
module tb_rom_load_sequencer;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        dn_download;
  logic        dn_wr;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        user_reset;
  logic        cpu_we, gfx_we, prom_we;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        core_reset, busy, rom_ok, addr_err;
  logic [7:0]  checksum;
  logic [16:0] byte_count;

  rom_load_sequencer dut (
    .clk_sys(clk_sys), .reset(reset), .dn_download(dn_download), .dn_wr(dn_wr),
    .dn_addr(dn_addr), .dn_data(dn_data), .user_reset(user_reset),
    .cpu_we(cpu_we), .gfx_we(gfx_we), .prom_we(prom_we), .wr_addr(wr_addr),
    .wr_data(wr_data), .core_reset(core_reset), .busy(busy), .rom_ok(rom_ok),
    .addr_err(addr_err), .checksum(checksum), .byte_count(byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  int errors = 0;
  int checks = 0;

  // Reference model of the current image, derived from the bytes issued.
  int         m_count;
  logic [7:0] m_sum;
  bit         m_err;
  int         bad_writes;
  int         cpu_n, gfx_n, prom_n;

  localparam logic [57:0] RESET_VEC = {3'b000, 16'h0, 8'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 17'h0};

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic clear_model();
    m_count = 0; m_sum = 8'h0; m_err = 0;
    bad_writes = 0; cpu_n = 0; gfx_n = 0; prom_n = 0;
  endtask

  // Issue one byte and check strobe/address/data/totals one cycle later.
  task automatic write_byte(input logic [15:0] a, input logic [7:0] d);
    logic [2:0]  exp_we;
    logic [15:0] rel;
    exp_we = 3'b000;
    rel    = 16'h0;
    if (a < 16'h4000)      begin exp_we = 3'b100; rel = a; end
    else if (a < 16'h5000) begin exp_we = 3'b010; rel = a - 16'h4000; end
    else if (a < 16'h5020) begin exp_we = 3'b001; rel = a - 16'h5000; end
    dn_wr = 1'b1; dn_addr = a; dn_data = d;
    tick();
    dn_wr = 1'b0;
    if (exp_we != 3'b000) begin m_count++; m_sum = m_sum + d; end
    else m_err = 1;
    cpu_n += int'(cpu_we); gfx_n += int'(gfx_we); prom_n += int'(prom_we);
    if ({cpu_we, gfx_we, prom_we} !== exp_we) bad_writes++;
    else if (exp_we != 3'b000 && (wr_addr !== rel || wr_data !== d)) bad_writes++;
    if (byte_count !== 17'(m_count) || checksum !== m_sum || addr_err !== m_err) bad_writes++;
  endtask

  task automatic begin_load();
    clear_model();
    dn_download = 1'b1;
    tick();
  endtask

  // Drop dn_download and count edges until core_reset falls (bounded).
  task automatic finish_load(output int n, output bit hold_seen);
    dn_download = 1'b0;
    tick();
    n = 1;
    hold_seen = (busy === 1'b1 && core_reset === 1'b1);
    while (core_reset === 1'b1 && n < 600) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; dn_download = 0; dn_wr = 0; dn_addr = 0; dn_data = 0; user_reset = 0;
    tick(); tick();
    checks++;
    if ({cpu_we, gfx_we, prom_we, wr_addr, wr_data, core_reset, busy, rom_ok, addr_err, checksum, byte_count} !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h",
        {cpu_we, gfx_we, prom_we, wr_addr, wr_data, core_reset, busy, rom_ok, addr_err, checksum, byte_count}, RESET_VEC);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_full_load();
    int n; bit hs;
    begin_load();
    checks++;
    if (busy !== 1'b1 || core_reset !== 1'b1) begin
      errors++; $display("FAIL load_entry: busy=%b core_reset=%b expected 1 1", busy, core_reset);
    end
    for (int a = 0; a < 16'h5020; a++) write_byte(16'(a), 8'(a));
    checks++;
    if (bad_writes !== 0) begin errors++; $display("FAIL full_write_stream: bad=%0d expected 0", bad_writes); end
    checks++;
    if (cpu_n !== 16'h4000 || gfx_n !== 16'h1000 || prom_n !== 16'h20) begin
      errors++; $display("FAIL full_strobe_counts: got %0h/%0h/%0h expected 4000/1000/20", cpu_n, gfx_n, prom_n);
    end
    checks++;
    if (byte_count !== 17'h5020 || checksum !== 8'hF0) begin
      errors++; $display("FAIL full_totals: got %h/%h expected 05020/f0", byte_count, checksum);
    end
    checks++;
    if (wr_addr !== 16'h001F) begin errors++; $display("FAIL last_prom_addr: got %h expected 001f", wr_addr); end
    finish_load(n, hs);
    checks++;
    if (!hs) begin errors++; $display("FAIL hold_entry: busy=%b core_reset=%b expected 1 1", busy, core_reset); end
    checks++;
    if (n !== 257) begin errors++; $display("FAIL full_release_time: got %0d expected 257", n); end
    checks++;
    if (rom_ok !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL full_run: rom_ok=%b busy=%b expected 1 0", rom_ok, busy);
    end
  endtask

  task automatic test_user_reset();
    int n;
    user_reset = 1'b1; tick(); user_reset = 1'b0;
    n = 1;
    while (core_reset === 1'b1 && n < 600) begin tick(); n++; end
    checks++;
    if (n !== 257) begin errors++; $display("FAIL user_reset_hold: got %0d expected 257", n); end
    checks++;
    if (rom_ok !== 1'b1) begin errors++; $display("FAIL user_reset_rom_ok: got %b expected 1", rom_ok); end
    // Second pulse mid-HOLD must not restart the count.
    user_reset = 1'b1; tick(); user_reset = 1'b0;
    n = 1;
    while (core_reset === 1'b1 && n < 600) begin
      if (n == 100) user_reset = 1'b1;
      tick();
      user_reset = 1'b0;
      n++;
    end
    checks++;
    if (n !== 257) begin errors++; $display("FAIL user_reset_no_restart: got %0d expected 257", n); end
  endtask

  task automatic test_abort();
    int n; bit hs;
    user_reset = 1'b1; tick(); user_reset = 1'b0;
    repeat (20) tick();
    dn_download = 1'b1;
    tick();
    checks++;
    if ({busy, core_reset, rom_ok, addr_err, checksum, byte_count} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'h0, 17'h0}) begin
      errors++;
      $display("FAIL abort_clear: busy=%b core_reset=%b rom_ok=%b cs=%h cnt=%h expected 1 1 0 00 00000",
        busy, core_reset, rom_ok, checksum, byte_count);
    end
    finish_load(n, hs);
    checks++;
    if (core_reset !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_empty_idle: core_reset=%b busy=%b expected 1 0", core_reset, busy);
    end
  endtask

  task automatic test_short_load();
    int n; bit hs;
    begin_load();
    for (int a = 0; a < 16'h4000; a++) write_byte(16'(a), 8'($urandom));
    checks++;
    if (bad_writes !== 0 || byte_count !== 17'h4000) begin
      errors++; $display("FAIL short_stream: bad=%0d cnt=%h expected 0 04000", bad_writes, byte_count);
    end
    finish_load(n, hs);
    checks++;
    if (!hs || core_reset !== 1'b1 || rom_ok !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL short_idle: hold=%b core_reset=%b rom_ok=%b busy=%b expected 1 1 0 0",
        hs, core_reset, rom_ok, busy);
    end
    // Stray byte strobe with no download active.
    dn_wr = 1'b1; dn_addr = 16'h0010; dn_data = 8'h5A;
    tick();
    dn_wr = 1'b0;
    checks++;
    if ({cpu_we, gfx_we, prom_we} !== 3'b000 || byte_count !== 17'h4000 || checksum !== m_sum) begin
      errors++; $display("FAIL stray_wr: we=%b cnt=%h cs=%h expected 000 04000 %h",
        {cpu_we, gfx_we, prom_we}, byte_count, checksum, m_sum);
    end
  endtask

  task automatic test_out_of_range();
    int n; bit hs;
    begin_load();
    for (int a = 0; a < 16'h5020; a++) write_byte(16'(a), 8'($urandom));
    write_byte(16'h6000, 8'hAA);
    checks++;
    if (bad_writes !== 0) begin errors++; $display("FAIL oor_stream: bad=%0d expected 0", bad_writes); end
    checks++;
    if (addr_err !== 1'b1 || byte_count !== 17'h5020 || checksum !== m_sum) begin
      errors++; $display("FAIL oor_totals: err=%b cnt=%h cs=%h expected 1 05020 %h", addr_err, byte_count, checksum, m_sum);
    end
    finish_load(n, hs);
    checks++;
    if (core_reset !== 1'b1 || rom_ok !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL oor_idle: core_reset=%b rom_ok=%b busy=%b expected 1 0 0", core_reset, rom_ok, busy);
    end
  endtask

  task automatic test_random_short();
    int n; bit hs; int len;
    logic [15:0] a;
    for (int it = 0; it < 6; it++) begin
      len = int'($urandom_range(40, 1));
      clear_model();
      dn_download = 1'b1;
      // Half the time the first byte rides on the download's entry cycle.
      if ($urandom_range(1, 0) == 0) tick();
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(3, 0) == 0) a = 16'h5020 + 16'($urandom_range(16'hAFDF, 0));
        else a = 16'($urandom_range(16'h501F, 0));
        write_byte(a, 8'($urandom));
        repeat ($urandom_range(2, 0)) tick();
      end
      checks++;
      if (bad_writes !== 0 || addr_err !== m_err || byte_count !== 17'(m_count) || checksum !== m_sum) begin
        errors++; $display("FAIL random_load_%0d: bad=%0d err=%b cnt=%h cs=%h expected 0 %b %h %h",
          it, bad_writes, addr_err, byte_count, checksum, m_err, 17'(m_count), m_sum);
      end
      finish_load(n, hs);
      checks++;
      if (!hs || core_reset !== 1'b1 || rom_ok !== 1'b0) begin
        errors++; $display("FAIL random_idle_%0d: hold=%b core_reset=%b rom_ok=%b expected 1 1 0", it, hs, core_reset, rom_ok);
      end
    end
  endtask

  task automatic test_async_reset();
    int n; bit hs; int busy_bad;
    begin_load();
    for (int a = 0; a < 10; a++) write_byte(16'(a), 8'(a + 3));
    reset = 1'b1;
    #1;
    checks++;
    if ({cpu_we, gfx_we, prom_we, wr_addr, wr_data, core_reset, busy, rom_ok, addr_err, checksum, byte_count} !== RESET_VEC) begin
      errors++;
      $display("FAIL async_reset_values: got %h expected %h",
        {cpu_we, gfx_we, prom_we, wr_addr, wr_data, core_reset, busy, rom_ok, addr_err, checksum, byte_count}, RESET_VEC);
    end
    tick(); tick();
    reset = 1'b0;
    busy_bad = 0;
    for (int k = 0; k < 5; k++) begin
      dn_wr = (k == 2); dn_addr = 16'h0001; dn_data = 8'h77;
      tick();
      dn_wr = 1'b0;
      if (busy !== 1'b0 || core_reset !== 1'b1 || cpu_we !== 1'b0 || byte_count !== 17'h0) busy_bad++;
    end
    checks++;
    if (busy_bad !== 0) begin errors++; $display("FAIL post_reset_idle: bad=%0d expected 0", busy_bad); end
    dn_download = 1'b0; tick();
    dn_download = 1'b1; tick();
    checks++;
    if (busy !== 1'b1 || core_reset !== 1'b1) begin
      errors++; $display("FAIL reload_after_reset: busy=%b core_reset=%b expected 1 1", busy, core_reset);
    end
    finish_load(n, hs);
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_user_reset();
    test_abort();
    test_short_load();
    test_out_of_range();
    test_random_short();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_load_sequencer.md
# rom_load_sequencer

Sequences the HPS ROM download stream into the Pisces core's ROM regions and owns the core reset. It decodes each download byte into a region-relative write strobe for program ROM, graphics ROM or colour PROM, and counts and checksums the image. It holds the core in reset until a complete image is loaded, then releases it after a fixed settle period. It sits between `hps_io` (ioctl outputs) and the `galaxian` core (`dn_*` inputs, `I_RESET`).

## Interface
Parameters:
- `CPU_END`, 16'h3FFF, last byte address of program ROM (base 16'h0000)
- `GFX_END`, 16'h4FFF, last byte address of graphics ROM (base `CPU_END`+1)
- `PROM_END`, 16'h501F, last byte address of colour PROM (base `GFX_END`+1)
- `HOLD_LEN`, 8'd255, number of clk_sys cycles that core_reset stays high after a load or a user reset

Ports:
- `clk_sys` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `dn_download` in 1: ioctl download-active level.
- `dn_wr` in 1: ioctl byte strobe, 1 cycle wide.
- `dn_addr` in 16: ioctl byte address.
- `dn_data` in 8: ioctl byte.
- `user_reset` in 1: OR of the OSD reset and the button reset.
- `cpu_we`, `gfx_we`, `prom_we` out 1 each: region write strobes, 1 cycle wide.
- `wr_addr` out 16: region-relative address, which is `dn_addr` minus the region base.
- `wr_data` out 8: registered `dn_data`.
- `core_reset` out 1: drives the core's `I_RESET`.
- `busy` out 1: high in LOAD and HOLD.
- `rom_ok` out 1: a complete image is present.
- `addr_err` out 1: sticky flag; an out-of-range write was seen during the current load.
- `checksum` out 8: mod-256 sum of the accepted bytes.
- `byte_count` out 17: number of accepted bytes, saturating at 17'h1FFFF.

## Operation
States and behaviour:
- **IDLE**: `core_reset`=1.
- **LOAD**: `core_reset`=1, `busy`=1.
- **HOLD**: `core_reset`=1, `busy`=1. An 8-bit counter counts up to `HOLD_LEN`.
- **RUN**: `core_reset`=0.

Transitions:
- Reset moves to IDLE.
- A rising edge on `dn_download` in any state moves to LOAD. Entry clears `checksum`, `byte_count`, `addr_err` and `rom_ok`. If entered from HOLD, the hold is aborted.
- LOAD moves to HOLD when `dn_download` is sampled low. The hold counter clears on entry.
- HOLD moves on once the counter reaches `HOLD_LEN`:
  - to RUN if `byte_count` is at least `PROM_END`+1 and `addr_err`=0; `rom_ok` is set the same cycle.
  - otherwise to IDLE, with `rom_ok`=0.
- RUN moves to HOLD when `user_reset`=1, which restarts the counter. `rom_ok` is kept.
- IDLE ignores `user_reset`.
- If `dn_download` rises in the same cycle as `user_reset`, the download wins and the next state is LOAD.

Write acceptance:
- A write is accepted only when `dn_wr`=1 and `dn_download`=1 are sampled in the same cycle, and the state is LOAD or the cycle that enters LOAD.
- A `dn_wr` seen outside a download is ignored: no strobe, no count.
- Region decode (inclusive ranges):
  - `dn_addr` ≤ `CPU_END` selects cpu.
  - ≤ `GFX_END` selects gfx.
  - ≤ `PROM_END` selects prom.
  - Anything higher asserts no strobe, sets `addr_err`, and does not update the checksum or count.
- An accepted in-range byte:
  - adds `dn_data` to `checksum`, mod 256, wrapping;
  - increments `byte_count`, holding at all ones once saturated.

Reset values: all strobes 0, `wr_addr`=0, `wr_data`=0, `core_reset`=1, `busy`=0, `rom_ok`=0, `addr_err`=0, `checksum`=0, `byte_count`=0.

## Timing
- All outputs are registered.
- Write latency is 1 cycle: `dn_wr` at cycle N gives the strobe, `wr_addr` and `wr_data` valid at N+1. `checksum` and `byte_count` update at N+1.
- Strobes are exactly 1 cycle wide. At most one region strobe is high in any cycle.
- Back-to-back `dn_wr` on consecutive cycles must be accepted with no gaps.
- `dn_download` falling in the same cycle as a `dn_wr`: the write is accepted if `dn_download` was sampled high in that cycle, otherwise it is dropped.
- `core_reset` release timing:
  - `dn_download` falls at cycle F, so HOLD is entered at F+1.
  - `core_reset` deasserts at F+1+`HOLD_LEN`+1.
  - The same count applies from the cycle in which `user_reset` is sampled.
- Asynchronous `reset` mid-load returns all state to reset values immediately. The loaded image is treated as invalid.
- `dn_download` must be re-asserted to leave IDLE.

## Test plan
- **Full load:** 0x5020 sequential bytes with data equal to addr[7:0], `dn_wr` every cycle.
  - `cpu_we`×0x4000, `gfx_we`×0x1000 with `wr_addr` 0..0xFFF, `prom_we`×0x20 with `wr_addr` 0..0x1F.
  - `byte_count`=0x5020, `checksum`=8'hF0.
  - `core_reset` falls 257 cycles after `dn_download` falls; `rom_ok`=1.
- **Short load:** 0x4000 bytes only. Expect HOLD, then IDLE, with `core_reset` still 1 and `rom_ok`=0.
- **Out of range:** a full load plus one write at 16'h6000.
  - That write produces no strobe; `addr_err`=1; `byte_count`=0x5020.
  - The block ends in IDLE.
- **User reset:** in RUN, pulse `user_reset` for 1 cycle.
  - `core_reset`=1 for exactly `HOLD_LEN`+1 cycles, then 0. `rom_ok` stays 1.
  - Pulse it again mid-HOLD and check the counter is not restarted.
- **Abort:** raise `dn_download` during HOLD. Expect LOAD with `checksum`, `byte_count` and `rom_ok` cleared and `core_reset` still 1.
  - A `dn_wr` with `dn_download`=0 produces no strobe and no count.
- **Async reset:** assert `reset` mid-load, 1 ns after a clock edge.
  - All outputs reach their reset values before the next edge.
  - The block stays in IDLE after release until `dn_download` rises.
